// File: rtl/sram_bus_arbiter.sv
// Merges instruction and data SRAM-like ports onto one master port; an in-order ID FIFO
// routes each returning response back to the requester whose address was accepted.
module sram_bus_arbiter #(
  parameter int MAX_OUTST  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [3:0]  m_wstrb,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err
);
  localparam int PW = $clog2(MAX_OUTST) + 1;
  localparam int AW = PW - 1;
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {(PW-1){1'b0}}};
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [MAX_OUTST-1:0] id_mem;
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        starve_cnt;
  logic                 err_q, full, empty, head, starved;
  logic                 sel_d, sel_i, push, pop;

  assign full    = (wptr ^ rptr) == FULL_XOR;
  assign empty   = wptr == rptr;
  assign head    = id_mem[rptr[AW-1:0]];
  assign starved = inst_req && (starve_cnt == LIM);
  assign sel_d   = data_req && !starved;
  assign sel_i   = inst_req && !sel_d;

  assign m_req        = (data_req || inst_req) && !full && !reset;
  assign data_addr_ok = sel_d && m_addr_ok && !full && !reset;
  assign inst_addr_ok = sel_i && m_addr_ok && !full && !reset;
  assign push         = m_req && m_addr_ok;
  assign pop          = m_data_ok && !empty && !reset;

  // Fetches always present as word-sized reads with no strobes.
  always_comb begin
    m_wr    = 1'b0;
    m_wstrb = 4'b0000;
    m_size  = 3'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (!reset && sel_d) begin
      m_wr    = data_wr;
      m_wstrb = data_wstrb;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else if (!reset && sel_i) begin
      m_size  = 3'd2;
      m_addr  = inst_addr;
    end
  end

  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'd0;
  assign err          = err_q && !reset;

  always_ff @(posedge clk) begin
    if (push) id_mem[wptr[AW-1:0]] <= sel_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (m_data_ok && empty) err_q <= 1'b1;
      if (inst_addr_ok || !inst_req)
        starve_cnt <= '0;
      else if (data_addr_ok && starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized and directed bench for sram_bus_arbiter: a transaction-level model predicts
// grants and pushes expected requester IDs; a monitor pops them as responses appear.
module tb_sram_bus_arbiter;
  localparam int MAX_OUTST  = 4;
  localparam int STARVE_LIM = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [2:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, err;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  sram_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  int          vec = 0;
  int          mis = 0;
  int          outst = 0;
  int          starve = 0;
  bit          err_exp = 1'b0;
  bit          exp_q[$];
  logic [31:0] cur_rdata = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw, input logic [3:0] ds, input logic [2:0] dsz,
                      input logic [31:0] da, input logic [31:0] dwd, input bit aok, input bit dok);
    bit gd, gi, full, acc, resp;
    @(negedge clk);
    reset = rst; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_wstrb = ds; data_size = dsz;
    data_addr = da; data_wdata = dwd;
    m_addr_ok = aok; m_data_ok = dok; m_rdata = $urandom; cur_rdata = m_rdata;
    #1;
    if (rst) begin
      chk("rst_ctrl", 64'({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err}), 64'd0);
      chk("rst_bus", {m_addr, m_wdata}, 64'd0);
      chk("rst_misc", 64'({m_wr, m_wstrb, m_size, inst_rdata, data_rdata}), 64'd0);
      outst = 0; starve = 0; err_exp = 1'b0;
      exp_q.delete();
    end else begin
      full = (outst >= MAX_OUTST);
      gd   = dr && !(ir && starve == STARVE_LIM);
      gi   = ir && !gd;
      acc  = (gd || gi) && aok && !full;
      resp = dok && (outst > 0);
      chk("m_req", 64'((dr || ir) && !full), 64'(m_req));
      chk("addr_ok", 64'({inst_addr_ok, data_addr_ok}),
          64'({gi && aok && !full, gd && aok && !full}));
      chk("resp_any", 64'(inst_data_ok || data_data_ok), 64'(resp));
      chk("err", 64'(err), 64'(err_exp));
      if (gd) begin
        chk("d_bus", {m_addr, m_wdata}, {da, dwd});
        chk("d_ctl", 64'({m_wr, m_wstrb, m_size}), 64'({dw, ds, dsz}));
      end else if (gi) begin
        chk("i_bus", {m_addr, m_wdata}, {ia, 32'd0});
        chk("i_ctl", 64'({m_wr, m_wstrb, m_size}), 64'({1'b0, 4'b0000, 3'd2}));
      end
      if (dok && outst == 0) err_exp = 1'b1;
      if (acc) exp_q.push_back(gd);
      outst = outst + int'(acc) - int'(resp);
      if (!ir || (gi && acc)) starve = 0;
      else if (gd && acc && starve < STARVE_LIM) starve++;
    end
  endtask

  task automatic cyc(input bit rst, input bit ir, input bit dr, input bit aok, input bit dok);
    step(rst, ir, $urandom, dr, 1'($urandom), 4'($urandom), 3'($urandom),
         $urandom, $urandom, aok, dok);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && outst > 0; i++) cyc(0, 0, 0, 0, 1);
    chk("drain_done", 64'(outst), 64'd0);
  endtask

  // Response monitor, decoupled from stimulus.
  initial begin
    bit exp_id;
    forever begin
      @(negedge clk);
      #2;
      if (inst_data_ok || data_data_ok) begin
        if (exp_q.size() == 0) begin
          vec++; mis++;
          $display("FAIL resp_unexpected: got inst=%0b data=%0b expected no response",
                   inst_data_ok, data_data_ok);
        end else begin
          exp_id = exp_q.pop_front();
          chk("resp_id", 64'({inst_data_ok, data_data_ok}), exp_id ? 64'd1 : 64'd2);
          chk("resp_rdata", 64'(data_data_ok ? data_rdata : inst_rdata), 64'(cur_rdata));
        end
      end
    end
  end

  initial begin
    logic [11:0] seq;
    bit ir, dr;
    reset = 1'b1; inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_wr = 0; data_wstrb = 0;
    data_size = 0; m_rdata = 0;
    cyc(1, 1, 1, 1, 1);
    cyc(1, 0, 0, 0, 0);

    // Single store/load through the data port.
    step(0, 0, 32'h0, 1, 0, 4'hf, 3'd2, 32'h1fc0_0010, 32'h0, 1, 0);
    chk("t1_addr", 64'(m_addr), 64'h1fc0_0010);
    cyc(0, 0, 0, 0, 1);

    // Starvation limit: D x8, I, D...
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1, 1, outst > 0);
      seq[i] = inst_addr_ok;
    end
    chk("starve_seq", 64'(seq), 64'(12'b0001_0000_0000));
    drain();

    // Fill to full, blocked push on pop cycle, refill next cycle.
    for (int i = 0; i < 4; i++) cyc(0, (i % 2) == 0, (i % 2) == 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    chk("full_mreq", 64'(m_req), 64'd0);
    cyc(0, 1, 0, 1, 1);
    chk("full_bubble", 64'(inst_addr_ok), 64'd0);
    cyc(0, 1, 0, 1, 1);
    chk("refill", 64'(inst_addr_ok), 64'd1);
    drain();

    // Steady push+pop at two outstanding.
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      ir = 1'($urandom);
      dr = !ir || 1'($urandom);
      cyc(0, ir, dr, 1, 1);
    end
    drain();

    // Reset with traffic in flight, then a clean fetch.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    step(0, 1, 32'hbfc0_0000, 0, 0, 4'h0, 3'd0, 32'h0, 32'h0, 1, 0);
    cyc(0, 0, 0, 0, 1);

    // Orphan response sets sticky err until reset.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk("err_sticky", 64'(err), 64'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("err_cleared", 64'(err), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 10) < 7,
          ($urandom % 10) < 6,
          (outst > 0) ? (($urandom % 2) == 1) : (($urandom % 100) == 0));
    end
    drain();
    cyc(0, 0, 0, 0, 0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
